load_store_unit: RTL and testbench

Sits between the RV32I core's execute stage and the word-wide data RAM. The RAM has one word-wide write enable and an asynchronous read. This unit turns core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM word accesses:
- Loads: selects and extends the addressed lane.
- Sub-word stores: performs a two-cycle read-modify-write.
- Stalls the core through `busy` while a multi-cycle access is in flight.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 81 ++++++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// the FSM state type and the default data width.
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: load lane extract with
// sign/zero extension, store lane merge into the current RAM word, and
// illegal-code / misalignment detection. Misaligned low address bits are
// simply ignored here (H uses addr[1], W uses the whole word); whether a
// misalignment traps is decided by the top module.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic        illegal_o,
  output logic        misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        is_half;

  assign is_half = (funct3_i[1:0] == 2'b01);

  // Pick the addressed byte and halfword out of the RAM word (little-endian).
  always_comb begin
    byte_lane = rd_i[7:0];
    case (addr_lo_i)
      2'd0: byte_lane = rd_i[7:0];
      2'd1: byte_lane = rd_i[15:8];
      2'd2: byte_lane = rd_i[23:16];
      2'd3: byte_lane = rd_i[31:24];
      default: byte_lane = rd_i[7:0];
    endcase
    half_lane = addr_lo_i[1] ? rd_i[31:16] : rd_i[15:0];
  end

  // Extend the selected lane to a full word according to the load type.
  always_comb begin
    load_o = 32'h0;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_o = {24'h0, byte_lane};
      F3_H:    load_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_o = {16'h0, half_lane};
      F3_W:    load_o = rd_i;
      default: load_o = 32'h0;
    endcase
  end

  // Replace the addressed store lane of the current RAM word with wdata.
  always_comb begin
    merge_o = rd_i;
    if (is_half) begin
      if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
      else              merge_o[15:0]  = wdata_i[15:0];
    end else begin
      case (addr_lo_i)
        2'd0: merge_o[7:0]   = wdata_i[7:0];
        2'd1: merge_o[15:8]  = wdata_i[7:0];
        2'd2: merge_o[23:16] = wdata_i[7:0];
        2'd3: merge_o[31:24] = wdata_i[7:0];
        default: merge_o = rd_i;
      endcase
    end
  end

  // Unsigned codes exist only for loads; everything else outside B/H/W is illegal.
  always_comb begin
    illegal_o = 1'b1;
    case (funct3_i)
      F3_B, F3_H, F3_W: illegal_o = 1'b0;
      F3_BU, F3_HU:     illegal_o = store_i;
      default:          illegal_o = 1'b1;
    endcase
    misalign_o = (is_half && addr_lo_i[0]) ||
                 ((funct3_i == F3_W) && (addr_lo_i != 2'b00));
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the RV32I execute stage and a word-wide RAM with
// asynchronous read and a single word write enable. Loads and SW finish in
// one cycle; SB/SH do a registered read-modify-write through the WRITE state.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses and
// flag illegal funct3 on err; otherwise err is 0 and low address bits are
// ignored).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_t        state_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [ADDR_W-3:0] waddr_q;
  logic              done_q;

  logic [DATA_W-1:0] load_d;
  logic [DATA_W-1:0] merge_d;
  logic              illegal;
  logic              misalign;
  logic              fault;
  logic              accept;
  logic              sw_now;

  lsu_align u_align (
    .funct3_i   (funct3),
    .store_i    (store),
    .addr_lo_i  (addr[1:0]),
    .wdata_i    (wdata),
    .rd_i       (mem_rd),
    .load_o     (load_d),
    .merge_o    (merge_d),
    .illegal_o  (illegal),
    .misalign_o (misalign)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign fault = illegal | misalign;
  assign err   = err_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign fault = illegal;
  assign err   = 1'b0;
`endif

  assign accept = (state_q == IDLE) && req;
  assign sw_now = accept && store && !fault && (funct3 == F3_W);

  // RAM side: the WRITE state replays the held word address and merged data;
  // reset gates the enable so no write can land on a reset edge.
  always_comb begin
    mem_addr = {2'b00, addr[ADDR_W-1:2]};
    mem_wd   = wdata;
    if (state_q == WRITE) begin
      mem_addr = {2'b00, waddr_q};
      mem_wd   = merge_q;
    end
    mem_we = !rst && ((state_q == WRITE) || sw_now);
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign busy  = (state_q == WRITE);

  // Request FSM with registered completion, load result and RMW merge word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      merge_q <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req) begin
            waddr_q <= addr[ADDR_W-1:2];
            done_q  <= 1'b1;
            if (fault) begin
              rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
              err_q   <= 1'b1;
`endif
            end else if (!store) begin
              rdata_q <= load_d;
            end else if (funct3 != F3_W) begin
              // Sub-word store: capture the merged word, finish next cycle.
              merge_q <= merge_d;
              done_q  <= 1'b0;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small asynchronous-read RAM.
// Inputs change on the falling edge; outputs are checked there or just after.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] ram [0:15];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign mem_rd = ram[mem_addr[3:0]];

  always @(posedge clk) if (mem_we) ram[mem_addr[3:0]] = mem_wd;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .store(store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .err(err), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[1] = 32'h1122_3344;
    ram[2] = 32'h8000_00FF;

    // Reset state
    @(negedge clk);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    rst = 1'b0;

    // LW at 0x8
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    #1;
    chk("lw_addr", mem_addr, 32'h2);
    chk("lw_we", {31'h0, mem_we}, 32'h0);
    chk("lw_busy0", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("lw_done", {31'h0, done}, 32'h1);
    chk("lw_rdata", rdata, 32'h8000_00FF);
    chk("lw_busy1", {31'h0, busy}, 32'h0);

    // LB / LBU / LH / LHU, back-to-back
    ram[2] = 32'h80FF_1234;
    issue(1'b0, 3'b000, 32'hB, 32'h0);
    @(negedge clk);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'hB, 32'h0);
    @(negedge clk);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    issue(1'b0, 3'b001, 32'hA, 32'h0);
    @(negedge clk);
    chk("lh_rdata", rdata, 32'hFFFF_80FF);
    issue(1'b0, 3'b101, 32'hA, 32'h0);
    @(negedge clk);
    chk("lhu_rdata", rdata, 32'h0000_80FF);
    chk("lhu_done", {31'h0, done}, 32'h1);
    req = 1'b0;
    @(negedge clk);
    chk("idle_done", {31'h0, done}, 32'h0);

    // SB 0xAA at 0x5
    issue(1'b1, 3'b000, 32'h5, 32'h5566_77AA);
    #1;
    chk("sb_acc_we", {31'h0, mem_we}, 32'h0);
    chk("sb_acc_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("sb_wr_busy", {31'h0, busy}, 32'h1);
    chk("sb_wr_we", {31'h0, mem_we}, 32'h1);
    chk("sb_wr_wd", mem_wd, 32'h1122_AA44);
    chk("sb_wr_addr", mem_addr, 32'h1);
    chk("sb_wr_done", {31'h0, done}, 32'h0);
    req = 1'b0;
    @(negedge clk);
    chk("sb_done", {31'h0, done}, 32'h1);
    chk("sb_busy", {31'h0, busy}, 32'h0);
    chk("sb_ram", ram[1], 32'h1122_AA44);
    chk("sb_rdata_kept", rdata, 32'h0000_80FF);

    // SH 0xBEEF at 0x6, then back-to-back LW at 0x4
    ram[1] = 32'h1122_3344;
    issue(1'b1, 3'b001, 32'h6, 32'h0000_BEEF);
    @(negedge clk);
    chk("sh_wr_wd", mem_wd, 32'hBEEF_3344);
    @(negedge clk);
    chk("sh_done", {31'h0, done}, 32'h1);
    chk("sh_rdata_kept", rdata, 32'h0000_80FF);
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    @(negedge clk);
    chk("b2b_done", {31'h0, done}, 32'h1);
    chk("b2b_rdata", rdata, 32'hBEEF_3344);
    req = 1'b0;

    // Reset during the WRITE cycle of SH
    ram[1] = 32'h1122_3344;
    @(negedge clk);
    issue(1'b1, 3'b001, 32'h4, 32'h0000_CAFE);
    @(negedge clk);
    chk("rsw_busy_pre", {31'h0, busy}, 32'h1);
    chk("rsw_we_pre", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    req = 1'b0;
    #1;
    chk("rsw_we", {31'h0, mem_we}, 32'h0);
    chk("rsw_busy", {31'h0, busy}, 32'h0);
    chk("rsw_done", {31'h0, done}, 32'h0);
    chk("rsw_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("rsw_ram", ram[1], 32'h1122_3344);
    chk("rsw_done2", {31'h0, done}, 32'h0);
    rst = 1'b0;

    // Reset high across the acceptance edge of SW
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h8, 32'h1234_5678);
    rst = 1'b1;
    #1;
    chk("rsa_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rsa_ram", ram[2], 32'h80FF_1234);
    chk("rsa_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    req = 1'b0;

    // Misaligned SW at 0x6
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF);
    #1;
    chk("mis_we", {31'h0, mem_we}, {31'h0, ~TRAP});
    @(negedge clk);
    chk("mis_done", {31'h0, done}, 32'h1);
    chk("mis_err", {31'h0, err}, {31'h0, TRAP});
    chk("mis_ram", ram[1], TRAP ? 32'h1122_3344 : 32'hDEAD_BEEF);

    // Load to get nonzero rdata, then illegal load funct3 011
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    @(negedge clk);
    chk("pre_ill_rdata", rdata, 32'h80FF_1234);
    chk("pre_ill_err", {31'h0, err}, 32'h0);
    issue(1'b0, 3'b011, 32'h8, 32'h0);
    #1;
    chk("ill_ld_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("ill_ld_done", {31'h0, done}, 32'h1);
    chk("ill_ld_rdata", rdata, 32'h0);
    chk("ill_ld_err", {31'h0, err}, {31'h0, TRAP});

    // Illegal store: store with unsigned byte code
    issue(1'b1, 3'b100, 32'h8, 32'h0000_0055);
    #1;
    chk("ill_st_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    chk("ill_st_done", {31'h0, done}, 32'h1);
    chk("ill_st_busy", {31'h0, busy}, 32'h0);
    chk("ill_st_err", {31'h0, err}, {31'h0, TRAP});
    req = 1'b0;
    @(negedge clk);
    chk("ill_st_ram", ram[2], 32'h80FF_1234);
    chk("ill_st_done2", {31'h0, done}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
